// File: rtl/execute_muldiv.sv
// Multi-cycle RV32M multiply/divide unit. It uses a radix-2 iterative datapath,
// with a valid/ready handshake on both the operand side and the result side.
module execute_muldiv #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     src_a_i,
  input  logic [WIDTH-1:0]     src_b_i,
  input  logic [REG_WIDTH-1:0] rd_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     result_o,
  output logic [REG_WIDTH-1:0] rd_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [REG_WIDTH-1:0] rd_q, rd_d;
  // The multiplicand for MUL ops, or the divisor magnitude for DIV ops.
  logic [WIDTH-1:0]     opd_q, opd_d;
  // MUL: {partial sum, multiplier}. DIV: {remainder, dividend/quotient}.
  logic [PW-1:0]        prod_q, prod_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 special;
  logic [WIDTH-1:0]     special_res;
  logic [WIDTH:0]       mul_sum;
  logic [PW-1:0]        mul_nxt;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [PW-1:0]        div_nxt;
  logic [PW-1:0]        step_nxt, prod_fin;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = result_q;
  assign rd_o        = rd_q;

  // Operand conditioning, special-case decode and one datapath iteration.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_i)
      3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'd2:             a_signed = 1'b1;
      default:          ;
    endcase
    a_neg = a_signed & src_a_i[WIDTH-1];
    b_neg = b_signed & src_b_i[WIDTH-1];
    a_mag = a_neg ? WIDTH'(-src_a_i) : src_a_i;
    b_mag = b_neg ? WIDTH'(-src_b_i) : src_b_i;

    special     = 1'b0;
    special_res = '0;
    if (op_i[2]) begin
      if (src_b_i == '0) begin
        special     = 1'b1;
        special_res = op_i[1] ? src_a_i : '1;
      end else if (!op_i[0] && (src_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&src_b_i)) begin
        special     = 1'b1;
        special_res = op_i[1] ? '0 : src_a_i;
      end
    end

    // Shift-add multiply step.
    mul_sum = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, opd_q} : '0);
    mul_nxt = {mul_sum, prod_q[WIDTH-1:1]};

    // Restoring divide step. The remainder is always below the divisor, so the shift fits in WIDTH+1 bits.
    div_shift = {prod_q[PW-1:WIDTH], prod_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    if (!div_diff[WIDTH])
      div_nxt = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    else
      div_nxt = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

    step_nxt = op_q[2] ? div_nxt : mul_nxt;
    prod_fin = neg_q ? PW'(-step_nxt) : step_nxt;
    quo_fix  = neg_q ? WIDTH'(-step_nxt[WIDTH-1:0]) : step_nxt[WIDTH-1:0];
    rem_fix  = neg_q ? WIDTH'(-step_nxt[PW-1:WIDTH]) : step_nxt[PW-1:WIDTH];
  end

  // Next-state logic. A flush overrides every other transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    opd_d    = opd_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i && !flush_i) begin
          op_d  = op_i;
          rd_d  = rd_i;
          cnt_d = '0;
          if (op_i[2]) begin
            opd_d  = b_mag;
            prod_d = {{WIDTH{1'b0}}, a_mag};
            neg_d  = op_i[1] ? a_neg : (a_neg ^ b_neg);
          end else begin
            opd_d  = a_mag;
            prod_d = {{WIDTH{1'b0}}, b_mag};
            neg_d  = a_neg ^ b_neg;
          end
          if (special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        prod_d = step_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
          case (op_q)
            3'd0:       result_d = prod_fin[WIDTH-1:0];
            3'd4, 3'd5: result_d = quo_fix;
            3'd6, 3'd7: result_d = rem_fix;
            default:    result_d = prod_fin[PW-1:WIDTH];
          endcase
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      opd_q    <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      opd_q    <= opd_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed testbench for execute_muldiv. All expected values are hand-computed.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic [4:0]  rd_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  execute_muldiv #(.WIDTH(32), .REG_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .src_a_i(src_a_i), .src_b_i(src_b_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .rd_o(rd_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Waits one edge, then samples 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and waits for out_valid. lat is the number of edges after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat);
    op_i = op; src_a_i = a; src_b_i = b; rd_i = rd; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // Runs a full op with out_ready high and checks latency, result and tag.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    out_ready_i = 1'b1;
    issue(op, a, b, rd, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result_o, exp);
    check({tag, "_rd"}, 32'(rd_o), 32'(rd));
    tick();
    check({tag, "_idle"}, 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] held_res;
    logic [4:0]  held_rd;

    #12;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", 32'(rd_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Multiply
    run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33);
    run_op("mulh_m1",3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 33);
    // Divide
    run_op("divu",   3'd5, 32'd100,      32'd7,        5'd6,  32'd14,       33);
    run_op("remu",   3'd7, 32'd100,      32'd7,        5'd7,  32'd2,        33);
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 33);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 33);
    // Special cases complete in one cycle
    run_op("div0",   3'd4, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1);
    run_op("remu0",  3'd7, 32'd5,        32'd0,        5'd11, 32'd5,        1);
    run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
    run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1);

    // Backpressure: result held while out_ready is low
    out_ready_i = 1'b0;
    issue(3'd5, 32'd1000, 32'd10, 5'd14, lat);
    check("bp_lat", 32'(lat), 32'd33);
    check("bp_res", result_o, 32'd100);
    held_res = result_o;
    held_rd  = rd_o;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(out_valid_o), 32'd1);
      check("bp_hold_res", result_o, held_res);
      check("bp_hold_rd", 32'(rd_o), 32'(held_rd));
      check("bp_in_ready", 32'(in_ready_o), 32'd0);
      check("bp_busy", 32'(busy_o), 32'd1);
    end
    out_ready_i = 1'b1;
    tick();
    check("bp_release_idle", 32'(in_ready_o), 32'd1);
    check("bp_release_valid", 32'(out_valid_o), 32'd0);
    run_op("bp_next", 3'd0, 32'd6, 32'd7, 5'd15, 32'd42, 33);

    // Flush during iteration 10, while a new op is also being offered
    op_i = 3'd5; src_a_i = 32'd50; src_b_i = 32'd5; rd_i = 5'd16; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("fl_busy_before", 32'(busy_o), 32'd1);
    flush_i = 1'b1; in_valid_i = 1'b1; op_i = 3'd0; src_a_i = 32'd3; src_b_i = 32'd3;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("fl_idle", 32'(in_ready_o), 32'd1);
    check("fl_busy", 32'(busy_o), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid_o) pulses++;
      tick();
    end
    check("fl_no_pulse", 32'(pulses), 32'd0);
    check("fl_not_accepted", 32'(busy_o), 32'd0);
    run_op("fl_next", 3'd7, 32'd23, 32'd5, 5'd17, 32'd3, 33);

    // Asynchronous reset in the middle of an op
    op_i = 3'd1; src_a_i = 32'd9; src_b_i = 32'd9; rd_i = 5'd18; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid_o), 32'd0);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_mid_ready", 32'(in_ready_o), 32'd1);
    run_op("rst_next", 3'd4, 32'hFFFFFF9C, 32'd7, 5'd19, 32'hFFFFFFF2, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
